// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module  : cpu_pkg
// Brief   : Shared widths, fetch-state encoding and opcode constants.
// Revision: 1.0
// ============================================================================
package cpu_pkg;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 32;
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  localparam logic [1:0] FETCH_IDLE   = 2'd0;
  localparam logic [1:0] FETCH_RUN    = 2'd1;
  localparam logic [1:0] FETCH_HALTED = 2'd2;

  typedef enum logic [3:0] {
    OP_ADD  = 4'b0100,
    OP_INC  = 4'b0101,
    OP_SUB  = 4'b0111,
    OP_BRN  = 4'b1011,
    OP_LD   = 4'b1110,
    OP_SVPC = 4'b1111
  } opcode_e;

  // Opcode occupies the top nibble of the instruction word.
  function automatic logic [3:0] opcode_of(input logic [31:0] instr);
    return instr[31:28];
  endfunction

endpackage
`default_nettype wire

// File: rtl/ifid_reg.sv
`default_nettype none
// ============================================================================
// Module  : ifid_reg
// Brief   : IF/ID pipeline register with load, flush and hold.
// Revision: 1.0
// ============================================================================
module ifid_reg
  import cpu_pkg::*;
#(
  parameter int unsigned          INSTR_W = DATA_W,
  parameter int unsigned          PC_W    = ADDR_W,
  parameter logic [INSTR_W-1:0]   NOP_VAL = INSTR_W'(NOP_WORD)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_load,
  input  logic               i_flush,
  input  logic [INSTR_W-1:0] i_instr,
  input  logic [PC_W-1:0]    i_pc,
  output logic [INSTR_W-1:0] o_instr,
  output logic [PC_W-1:0]    o_pc,
  output logic               o_valid
);

  logic [INSTR_W-1:0] r_instr;
  logic [PC_W-1:0]    r_pc;
  logic               r_valid;

  // Flush outranks load; with neither asserted the contents hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_instr <= NOP_VAL;
      r_pc    <= '0;
      r_valid <= 1'b0;
    end else if (i_flush) begin
      r_instr <= NOP_VAL;
      r_pc    <= '0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_instr <= i_instr;
      r_pc    <= i_pc;
      r_valid <= 1'b1;
    end
  end

  assign o_instr = r_instr;
  assign o_pc    = r_pc;
  assign o_valid = r_valid;

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module  : fetch_unit
// Brief   : PC, start/halt FSM and redirect handling feeding the IF/ID register.
// Revision: 1.0
// ============================================================================
module fetch_unit #(
  parameter int unsigned        ADDR_W   = cpu_pkg::ADDR_W,
  parameter int unsigned        DATA_W   = cpu_pkg::DATA_W,
  parameter int unsigned        RESET_PC = 0,
  parameter int unsigned        LAST_PC  = 53,
  parameter logic [DATA_W-1:0]  NOP_WORD = DATA_W'(cpu_pkg::NOP_WORD)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_data,
  output logic [DATA_W-1:0] ifid_instr,
  output logic [ADDR_W-1:0] ifid_pc,
  output logic              ifid_valid,
  output logic              running,
  output logic              halted,
  output logic [15:0]       fetch_count
);
  import cpu_pkg::*;

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [15:0]       r_fetch_count;

  logic w_in_idle;
  logic w_in_run;
  logic w_in_halt;
  logic w_redirect;
  logic w_fire;
  logic w_flush;
  logic w_at_last;

  assign w_in_idle  = (r_state == FETCH_IDLE);
  assign w_in_run   = (r_state == FETCH_RUN);
  assign w_in_halt  = (r_state == FETCH_HALTED);
  assign w_redirect = branch_taken & (w_in_run | w_in_halt);
  assign w_fire     = w_in_run & ~branch_taken & ~stall;
  assign w_at_last  = (r_pc == ADDR_W'(LAST_PC));
  // IDLE and HALTED keep feeding bubbles; a RUN stall leaves IF/ID untouched.
  assign w_flush    = w_redirect | w_in_halt | w_in_idle;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= FETCH_IDLE;
    end else begin
      case (r_state)
        FETCH_IDLE: begin
          if (start) r_state <= FETCH_RUN;
        end
        FETCH_RUN: begin
          if (!branch_taken && w_fire && w_at_last) r_state <= FETCH_HALTED;
        end
        FETCH_HALTED: begin
          if (branch_taken) r_state <= FETCH_RUN;
        end
        default: r_state <= FETCH_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pc <= ADDR_W'(RESET_PC);
    end else if (w_redirect) begin
      r_pc <= branch_target;
    end else if (w_fire) begin
      r_pc <= r_pc + ADDR_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_fetch_count <= 16'h0000;
    end else if (w_fire && (r_fetch_count != 16'hFFFF)) begin
      r_fetch_count <= r_fetch_count + 16'h0001;
    end
  end

  ifid_reg #(
    .INSTR_W (DATA_W),
    .PC_W    (ADDR_W),
    .NOP_VAL (NOP_WORD)
  ) u_ifid_reg (
    .clk     (clock),
    .rst     (reset),
    .i_load  (w_fire),
    .i_flush (w_flush),
    .i_instr (imem_data),
    .i_pc    (r_pc),
    .o_instr (ifid_instr),
    .o_pc    (ifid_pc),
    .o_valid (ifid_valid)
  );

  assign imem_addr   = r_pc;
  assign running     = w_in_run;
  assign halted      = w_in_halt;
  assign fetch_count = r_fetch_count;

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage that sits directly upstream of instruction_memory.
- Owns the program counter and drives the memory address.
- Captures the combinational instruction word, with its PC, into the IF/ID pipeline register for decode.
- Handles start/halt sequencing, decode-side stall, and redirect from the branch unit (brn/jump). Software supplies NOP padding for data hazards.

Parameters:
- ADDR_W, 8, PC / instruction-memory address width.
- DATA_W, 32, instruction width.
- RESET_PC, 0, PC value after reset and the first fetch address.
- LAST_PC, 53, address of the final program word; fetching it ends the run.
- NOP_WORD, 0, word injected into IF/ID on flush or bubble.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  level; in IDLE, begins fetching.
- stall  in  1  holds PC and IF/ID contents.
- branch_taken  in  1  redirect request from execute stage.
- branch_target  in  ADDR_W  redirect address, valid with branch_taken.
- imem_addr  out  ADDR_W  address to instruction_memory (equals PC register).
- imem_data  in  DATA_W  instruction word from instruction_memory; combinational, same cycle.
- ifid_instr  out  DATA_W  registered instruction to decode.
- ifid_pc  out  ADDR_W  PC of ifid_instr (svpc uses it).
- ifid_valid  out  1  ifid_instr is a real fetch, not a bubble.
- running  out  1  state == RUN.
- halted  out  1  state == HALTED.
- fetch_count  out  16  number of valid fetches since reset, saturating at 16'hFFFF.

Behaviour:
- Reset (async, immediate):
  - pc = RESET_PC; state = IDLE.
  - ifid_instr = NOP_WORD; ifid_pc = 0; ifid_valid = 0.
  - fetch_count = 0; running = 0; halted = 0.
- imem_addr = pc continuously. There is no extra latency: the word at pc is sampled at the same edge pc advances.
- FSM states: IDLE, RUN, HALTED. Priority at every edge, highest first: reset > branch_taken > stall > normal.
- IDLE:
  - IF/ID holds NOP/invalid; pc is held.
  - start=1 → RUN. No fetch is captured on that edge; the first capture is on the next edge.
  - branch_taken is ignored.
- RUN, normal fetch (no branch, no stall):
  - ifid_instr <= imem_data; ifid_pc <= pc; ifid_valid <= 1.
  - pc <= pc+1, mod 2^ADDR_W (255 wraps to 0).
  - fetch_count increments.
- RUN, pc == LAST_PC on a normal fetch:
  - The fetch is captured as above.
  - pc <= pc+1; state <= HALTED.
- RUN, stall=1 and no branch: pc, IF/ID, fetch_count all hold.
- branch_taken=1 in RUN or HALTED (stall is ignored):
  - pc <= branch_target.
  - ifid_instr <= NOP_WORD; ifid_valid <= 0; ifid_pc <= 0 (wrong-path word discarded).
  - fetch_count is unchanged; state <= RUN.
  - This applies even if the same-cycle pc == LAST_PC; branch wins.
- HALTED, no branch:
  - pc holds.
  - IF/ID loads NOP_WORD with valid 0 every edge, so the pipeline drains.
  - start is ignored; only reset or branch_taken leaves HALTED.
- Outputs running and halted are registered, i.e. direct decodes of the state register.
- Reset mid-run: everything returns to reset values immediately; the next start refetches from RESET_PC.

Decomposition:
- Shared package cpu_pkg:
  - ADDR_W, DATA_W, NOP_WORD.
  - Fetch-state encoding: IDLE=2'd0, RUN=2'd1, HALTED=2'd2.
  - Opcode constants (BRN=4'b1011, SVPC=4'b1111, LD=4'b1110, INC=4'b0101, ADD=4'b0100, SUB=4'b0111) for decode and bench reuse.
- One natural sub-module: ifid_reg (instr, pc, valid with load/flush/hold controls).
- The PC/FSM logic stays in fetch_unit.

Test Plan:
- Reset, start pulse, no stall/branch, connected to instruction_memory → ifid_pc 0,1,2 on consecutive cycles; ifid_instr at pc 2 = 32'h71041000; ifid_valid=1 from the second edge after start.
- Stall held 3 cycles while pc=7 → imem_addr stays 7; ifid_instr stays 32'h5104FC00 (after capture); fetch_count unchanged; resumes at 8 on release.
- branch_taken=1, branch_target=21 while pc=36 → next edge pc=21, ifid_valid=0, ifid_instr=0; following edge ifid_pc=21, ifid_valid=1.
- Branch and stall asserted together, target=10 → branch wins: pc=10, IF/ID flushed.
- Run to LAST_PC=53 → word 53 captured with valid=1; halted=1 next; pc=54 thereafter; ifid_valid=0; start ignored; branch_taken to 10 restarts RUN at 10.
- Async reset asserted mid-cycle during RUN at pc=30 → outputs zero immediately without a clock edge; after release plus start, fetch resumes from 0 and fetch_count restarts from 0.
